// File: rtl/dcache_amo_arbiter_pkg.sv
// dcache_amo_arbiter_pkg: shared widths, atomic op codes, arbiter state and request bundle
package dcache_amo_arbiter_pkg;
  localparam int XLEN        = 64;
  localparam int PADDR_SIZE  = 56;
  localparam int AMOOP_WIDTH = 5;
  localparam int DCACHE_BYTE = 8;
  localparam logic [AMOOP_WIDTH-1:0] AMOADD  = 5'h00;
  localparam logic [AMOOP_WIDTH-1:0] AMOSWAP = 5'h01;
  localparam logic [AMOOP_WIDTH-1:0] AMOXOR  = 5'h04;
  localparam logic [AMOOP_WIDTH-1:0] AMOOR   = 5'h08;
  localparam logic [AMOOP_WIDTH-1:0] AMOAND  = 5'h0c;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} AmoArbState;
  typedef struct packed {
    logic [PADDR_SIZE-1:0]  paddr;
    logic [XLEN-1:0]        data;
    logic [AMOOP_WIDTH-1:0] op;
    logic [DCACHE_BYTE-1:0] mask;
    logic                   word;
  } AmoReqBundle;
endpackage

// File: rtl/amo_rr_pick.sv
// amo_rr_pick: combinational round-robin picker, first eligible at or after rr_ptr with wrap
module amo_rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [REQ_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [REQ_W-1:0]   idx_o
);
  logic hit;
  // scan from the pointer, keep the first hit
  always_comb begin
    hit   = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && eligible_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        hit   = 1'b1;
        idx_o = REQ_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      end
    end
    grant_o = hit ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/dcache_amo_arbiter.sv
// dcache_amo_arbiter: shares the DCache atomic port among requesters, owning the handshake until success
module dcache_amo_arbiter
  import dcache_amo_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NUM_REQ-1:0]                      req_i,
  input  logic [NUM_REQ-1:0][PADDR_SIZE-1:0]      req_paddr_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]            req_data_i,
  input  logic [NUM_REQ-1:0][AMOOP_WIDTH-1:0]     req_op_i,
  input  logic [NUM_REQ-1:0][DCACHE_BYTE-1:0]     req_mask_i,
  input  logic [NUM_REQ-1:0]                      req_word_i,
  input  logic [NUM_REQ-1:0]                      cancel_i,
  output logic [NUM_REQ-1:0]                      grant_o,
  output logic [NUM_REQ-1:0]                      success_o,
  output logic [XLEN-1:0]                         rdata_o,
  output logic                                    busy_o,
  output logic                                    c_req_o,
  output logic [PADDR_SIZE-1:0]                   c_paddr_o,
  output logic [XLEN-1:0]                         c_data_o,
  output logic [AMOOP_WIDTH-1:0]                  c_op_o,
  output logic [DCACHE_BYTE-1:0]                  c_mask_o,
  output logic                                    c_word_o,
  input  logic                                    c_ready_i,
  input  logic                                    c_success_i,
  input  logic                                    c_refill_i,
  input  logic [XLEN-1:0]                         c_rdata_i
);
  AmoArbState           state_q, state_d;
  logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx, next_ptr;
  logic [NUM_REQ-1:0]   grant_q, grant_d, pick_grant, eligible;
  logic                 killed_q, killed_d, c_req_q, c_req_d, latch, own_cancel;
  AmoReqBundle          payload_q, sel_req;

  assign eligible   = req_i & ~cancel_i;
  assign own_cancel = cancel_i[owner_q];
  assign next_ptr   = (owner_q == REQ_W'(NUM_REQ - 1)) ? '0 : owner_q + REQ_W'(1);

  amo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_grant),
    .idx_o      (pick_idx)
  );

  // payload of the requester the picker selected this cycle
  always_comb begin
    sel_req = '{paddr: req_paddr_i[pick_idx], data: req_data_i[pick_idx], op: req_op_i[pick_idx],
                mask: req_mask_i[pick_idx], word: req_word_i[pick_idx]};
  end

  // next state: grant in IDLE, hand over to the cache in ISSUE, wait for success or refill replay in WAIT
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    c_req_d  = c_req_q;
    grant_d  = '0;
    latch    = 1'b0;
    case (state_q)
      IDLE: if (|eligible) begin
        state_d  = ISSUE;
        owner_d  = pick_idx;
        killed_d = 1'b0;
        c_req_d  = 1'b1;
        grant_d  = pick_grant;
        latch    = 1'b1;
      end
      ISSUE: if (c_ready_i && c_req_q) begin
        state_d  = WAIT;
        c_req_d  = 1'b0;
        killed_d = killed_q | own_cancel;
      end else if (own_cancel) begin
        state_d = IDLE;
        c_req_d = 1'b0;
      end
      WAIT: begin
        killed_d = killed_q | own_cancel;
        if (c_success_i) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (c_refill_i) begin
          state_d = ISSUE;
          c_req_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      killed_q <= 1'b0;
      c_req_q  <= 1'b0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      c_req_q  <= c_req_d;
      grant_q  <= grant_d;
    end
  end

  // payload frozen from grant until the op retires; no reset needed
  always_ff @(posedge clk_i) begin
    if (latch) payload_q <= sel_req;
  end

  // success only to a live owner; rdata only visible while waiting on the cache
  always_comb begin
    success_o = (state_q == WAIT && c_success_i && !killed_q && !own_cancel) ? (NUM_REQ'(1) << owner_q) : '0;
    rdata_o   = (state_q == WAIT) ? c_rdata_i : '0;
  end

  assign grant_o   = grant_q;
  assign busy_o    = state_q != IDLE;
  assign c_req_o   = c_req_q;
  assign c_paddr_o = payload_q.paddr;
  assign c_data_o  = payload_q.data;
  assign c_op_o    = payload_q.op;
  assign c_mask_o  = payload_q.mask;
  assign c_word_o  = payload_q.word;
endmodule

// File: tb/tb_dcache_amo_arbiter.sv
// tb_dcache_amo_arbiter: cycle-table checks plus refill-replay and async-reset sequences
module tb_dcache_amo_arbiter;
  import dcache_amo_arbiter_pkg::*;
  localparam int N = 2;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic [N-1:0] req_i = '0, cancel_i = '0, req_word_i = '0;
  logic [N-1:0][PADDR_SIZE-1:0] req_paddr_i;
  logic [N-1:0][XLEN-1:0] req_data_i;
  logic [N-1:0][AMOOP_WIDTH-1:0] req_op_i;
  logic [N-1:0][DCACHE_BYTE-1:0] req_mask_i;
  logic [N-1:0] grant_o, success_o;
  logic [XLEN-1:0] rdata_o, c_data_o, c_rdata_i = '0;
  logic busy_o, c_req_o, c_word_o;
  logic [PADDR_SIZE-1:0] c_paddr_o;
  logic [AMOOP_WIDTH-1:0] c_op_o;
  logic [DCACHE_BYTE-1:0] c_mask_o;
  logic c_ready_i = 1'b0, c_success_i = 1'b0, c_refill_i = 1'b0;

  always #5 clk_i = ~clk_i;

  dcache_amo_arbiter #(.NUM_REQ(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_paddr_i(req_paddr_i), .req_data_i(req_data_i),
    .req_op_i(req_op_i), .req_mask_i(req_mask_i), .req_word_i(req_word_i), .cancel_i(cancel_i),
    .grant_o(grant_o), .success_o(success_o), .rdata_o(rdata_o), .busy_o(busy_o), .c_req_o(c_req_o),
    .c_paddr_o(c_paddr_o), .c_data_o(c_data_o), .c_op_o(c_op_o), .c_mask_o(c_mask_o), .c_word_o(c_word_o),
    .c_ready_i(c_ready_i), .c_success_i(c_success_i), .c_refill_i(c_refill_i), .c_rdata_i(c_rdata_i)
  );

  typedef struct {
    logic [1:0] req, cancel;
    logic rdy, suc, rfl;
    logic [63:0] cdat;
    logic [1:0] grant, success;
    logic busy, creq;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0, n_err = 0;

  function automatic vec_t mk(logic [1:0] req, logic [1:0] cancel, logic rdy, logic suc, logic rfl,
                              logic [63:0] cdat, logic [1:0] g, logic [1:0] s, logic busy, logic creq,
                              logic [63:0] rd);
    vec_t t;
    t.req = req; t.cancel = cancel; t.rdy = rdy; t.suc = suc; t.rfl = rfl; t.cdat = cdat;
    t.grant = g; t.success = s; t.busy = busy; t.creq = creq; t.rdata = rd;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t t, int i);
    @(negedge clk_i);
    req_i = t.req; cancel_i = t.cancel; c_ready_i = t.rdy; c_success_i = t.suc;
    c_refill_i = t.rfl; c_rdata_i = t.cdat;
    #1;
    chk($sformatf("v%0d grant", i), 64'(grant_o), 64'(t.grant));
    chk($sformatf("v%0d success", i), 64'(success_o), 64'(t.success));
    chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(t.busy));
    chk($sformatf("v%0d c_req", i), 64'(c_req_o), 64'(t.creq));
    chk($sformatf("v%0d rdata", i), rdata_o, t.rdata);
  endtask

  localparam logic [PADDR_SIZE-1:0] PA = PADDR_SIZE'(64'h8000_1000);
  localparam logic [XLEN-1:0] DA = 64'h0123_4567_89ab_cdef;

  initial begin
    req_paddr_i[0] = PA;                 req_paddr_i[1] = PADDR_SIZE'(64'h9000_2000);
    req_data_i[0]  = DA;                 req_data_i[1]  = 64'h1;
    req_op_i[0]    = AMOXOR;             req_op_i[1]    = AMOADD;
    req_mask_i[0]  = 8'hff;              req_mask_i[1]  = 8'h0f;
    // contention from reset: 0 first, then 1 after the idle bubble
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 1, 0, 64'h11, 2'b00, 2'b01, 1, 0, 64'h11));
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b10, 2'b00, 0, 1, 0, 64'h22, 2'b00, 2'b10, 1, 0, 64'h22));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // single op: ready at +2, rdata passthrough in WAIT, success with 0x5
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 64'h77, 2'b00, 2'b00, 1, 0, 64'h77));
    tbl.push_back(mk(2'b01, 2'b00, 0, 1, 0, 64'h5, 2'b00, 2'b01, 1, 0, 64'h5));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 64'h9, 2'b00, 2'b00, 0, 0, 0));
    // cancelled request is not eligible
    tbl.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // cancel in ISSUE before ready
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // cancel in WAIT: op completes silently
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 1, 0, 64'h33, 2'b00, 2'b00, 1, 0, 64'h33));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // cancel coincident with acceptance: killed, no success later
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 2'b10, 1, 0, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // success and refill together: success wins
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 1, 1, 64'h44, 2'b00, 2'b01, 1, 0, 64'h44));
    tbl.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 2'b10, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b10, 2'b00, 0, 1, 0, 64'h55, 2'b00, 2'b10, 1, 0, 64'h55));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    // pointer wrapped to 0: both requesting picks 0
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));

    #2 rst_ni = 1'b0;
    #1;
    chk("reset grant", 64'(grant_o), 0);
    chk("reset success", 64'(success_o), 0);
    chk("reset busy", 64'(busy_o), 0);
    chk("reset c_req", 64'(c_req_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // refill replay with payload frozen against requester changes
    @(negedge clk_i); req_i = 2'b01;
    @(negedge clk_i); #1;
    chk("rf grant", 64'(grant_o), 64'(2'b01));
    chk("rf paddr", 64'(c_paddr_o), 64'(PA));
    chk("rf mask", 64'(c_mask_o), 64'hff);
    req_paddr_i[0] = '1; req_data_i[0] = '0; req_op_i[0] = AMOAND;
    c_ready_i = 1'b1;
    @(negedge clk_i); c_ready_i = 1'b0; c_refill_i = 1'b1; #1;
    chk("rf wait busy", 64'(busy_o), 1);
    chk("rf wait c_req", 64'(c_req_o), 0);
    @(negedge clk_i); c_refill_i = 1'b0; #1;
    chk("rf replay c_req", 64'(c_req_o), 1);
    chk("rf replay paddr", 64'(c_paddr_o), 64'(PA));
    chk("rf replay data", c_data_o, DA);
    chk("rf replay op", 64'(c_op_o), 64'(AMOXOR));
    chk("rf replay grant", 64'(grant_o), 0);
    chk("rf replay success", 64'(success_o), 0);
    c_ready_i = 1'b1;
    @(negedge clk_i); c_ready_i = 1'b0; c_success_i = 1'b1; c_rdata_i = 64'h99; #1;
    chk("rf success", 64'(success_o), 64'(2'b01));
    chk("rf rdata", rdata_o, 64'h99);
    @(negedge clk_i); c_success_i = 1'b0; req_i = 2'b00; #1;
    chk("rf done success", 64'(success_o), 0);
    chk("rf done busy", 64'(busy_o), 0);

    // async reset in WAIT, then clean resumption
    @(negedge clk_i); req_i = 2'b10;
    @(negedge clk_i); c_ready_i = 1'b1;
    @(negedge clk_i); c_ready_i = 1'b0; c_rdata_i = 64'hdead; #1;
    chk("ar wait busy", 64'(busy_o), 1);
    chk("ar wait rdata", rdata_o, 64'hdead);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar busy", 64'(busy_o), 0);
    chk("ar c_req", 64'(c_req_o), 0);
    chk("ar grant", 64'(grant_o), 0);
    chk("ar rdata", rdata_o, 0);
    @(negedge clk_i); rst_ni = 1'b1; req_i = 2'b11;
    @(negedge clk_i); #1;
    chk("ar resume grant", 64'(grant_o), 64'(2'b01));
    chk("ar resume c_req", 64'(c_req_o), 1);
    c_ready_i = 1'b1;
    @(negedge clk_i); c_ready_i = 1'b0; c_success_i = 1'b1; c_rdata_i = 64'h7; #1;
    chk("ar resume success", 64'(success_o), 64'(2'b01));
    @(negedge clk_i); c_success_i = 1'b0; req_i = 2'b00; #1;
    chk("ar resume idle", 64'(busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
